sram_bus_arbiter: RTL
=====================

Name: sram_bus_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch side (pc_now/instrF) and the data side (memenM/data_sram_*) of the pipeline datapath. The block serialises requests through a fixed-priority FSM and buffers each completed response. It generates the datapath's i_stall and d_stall inputs. Completed responses are held stable until the pipeline leaves its stall (longest_stall low), so a request that finishes early is never re-issued.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; byte-enable width is DATA_W/8
DATA_FIRST, 1, 1 = data side wins simultaneous requests; 0 = instruction side wins

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
inst_req  in  1  fetch request, held high while the pipeline wants an instruction
inst_addr  in  ADDR_W  fetch address (pc_now)
inst_rdata  out  DATA_W  buffered fetched word (instrF)
i_stall  out  1  fetch not yet complete
data_req  in  1  data access request (memenM)
data_wen  in  DATA_W/8  byte write enables; 0 = load
data_addr  in  ADDR_W  data address (data_sram_waddr)
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  buffered load word (data_sram_rdataM)
d_stall  out  1  data access not yet complete
longest_stall  in  1  pipeline-wide stall from the datapath
mem_req  out  1  memory address-phase request
mem_wr  out  1  1 = write
mem_wstrb  out  DATA_W/8  byte strobes
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_addr_ok  in  1  address phase accepted
mem_data_ok  in  1  data phase complete; mem_rdata valid
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE; inst_done=data_done=0; inst_buf=data_buf=0; mem_req=0.
  - A mem_data_ok arriving after reset while in IDLE is ignored.
- FSM states: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA. Encoding is 3-bit.
- IDLE transitions:
  - data pending = data_req & ~data_done; inst pending = inst_req & ~inst_done.
  - Both pending: DATA_FIRST picks D_ADDR or I_ADDR.
  - One pending: go to its ADDR state.
  - Neither pending: stay in IDLE.
- X_ADDR states:
  - mem_req=1.
  - mem_* fields are driven from the owning side: for data, mem_wr=|data_wen and mem_wstrb=data_wen; for inst, mem_wr=0 and mem_wstrb=0.
  - mem_addr_ok -> X_DATA; otherwise hold and keep all fields stable.
- X_DATA states:
  - mem_req=0.
  - mem_data_ok -> capture mem_rdata into X_buf (also on writes; the value is don't-care), set X_done, go to IDLE.
- Minimum latency, request to stall release: 3 cycles (ADDR, DATA with same-cycle data_ok, then the registered done flag).
- The next transaction starts from IDLE. Example: data completes, and inst is issued one cycle later.
- Stall outputs:
  - i_stall = inst_req & ~inst_done; d_stall = data_req & ~data_done.
  - Both are combinational from registers and inputs only, with no path from mem_* inputs.
- Read data outputs: inst_rdata=inst_buf and data_rdata=data_buf, held stable while the corresponding done flag is 1.
- Done clear:
  - On a clock edge with longest_stall=0, both done flags clear.
  - If a set and a clear coincide, the set wins.
- Requester drops its request mid-flight (e.g. flush):
  - The FSM still completes the bus transaction, because the memory protocol cannot abort.
  - The done flag is set, then cleared at the next longest_stall=0.
- Arbitration is evaluated only in IDLE. There is no preemption of an in-flight transaction.

Decomposition:
- FSM state encodings (ARB_IDLE, ARB_D_ADDR, ARB_D_DATA, ARB_I_ADDR, ARB_I_DATA) go in defines.vh as shared constants.
- No sub-module is needed. The FSM, two done flags and two response buffers fit in one module of about 150–200 lines.

Test Plan:
- Reset then idle: rst pulse, no requests -> mem_req=0, i_stall=d_stall=0, both rdata=0.
- Single fetch: inst_req=1, inst_addr=0xBFC00000, addr_ok after 1 cycle, data_ok next cycle with 0x3C08BFAF -> exactly one mem_req transaction with mem_wr=0; i_stall falls 1 cycle after data_ok; inst_rdata=0x3C08BFAF held until longest_stall=0.
- Simultaneous requests: inst_req=1 and data_req=1 (load from 0x1FAF0000, rdata 0x12345678) with DATA_FIRST=1 -> data transaction first, then fetch; d_stall falls first; no second data transaction while i_stall is still high.
- Store: data_req=1, data_wen=4'b0011, data_wdata=0xAABBCCDD, data_addr=0x00000100 -> mem_wr=1, mem_wstrb=0011, and fields stay stable across 4 cycles of addr_ok=0.
- Hold behaviour: longest_stall held at 1 for 5 cycles after the fetch completes -> no new mem_req for inst; inst_rdata unchanged; done clears on the first edge with longest_stall=0.
- Async reset in I_DATA, then a late mem_data_ok -> state=IDLE immediately; inst_buf stays 0; i_stall=inst_req.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter_pkg
// Brief    : Shared FSM encodings and arbitration helper for sram_bus_arbiter
// Revision : 1.0 - initial release
// ============================================================================
package sram_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_D_ADDR = 3'd1,
        ARB_D_DATA = 3'd2,
        ARB_I_ADDR = 3'd3,
        ARB_I_DATA = 3'd4
    } arb_state_t;

    // Selects the data side when it is pending and either wins ties or has no rival.
    function automatic logic pickData(input logic dataPend, input logic instPend,
                                      input logic dataFirst);
        return dataPend & (dataFirst | ~instPend);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Brief    : Fixed-priority sharing of one SRAM-like port between fetch and data
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DATA_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  i_stall,
    input  logic                  data_req,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  d_stall,
    input  logic                  longest_stall,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic c_DATA_FIRST = (DATA_FIRST != 0);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic              r_instDone;
    logic              r_dataDone;
    logic [DATA_W-1:0] r_instBuf;
    logic [DATA_W-1:0] r_dataBuf;
    logic              w_instPend;
    logic              w_dataPend;
    logic              w_instSet;
    logic              w_dataSet;

    assign w_instPend = inst_req & ~r_instDone;
    assign w_dataPend = data_req & ~r_dataDone;

    // Stalls depend only on registers and requester inputs, never on mem_* handshakes.
    assign i_stall    = w_instPend;
    assign d_stall    = w_dataPend;
    assign inst_rdata = r_instBuf;
    assign data_rdata = r_dataBuf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_wstrb   = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_instSet   = 1'b0;
        w_dataSet   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (pickData(w_dataPend, w_instPend, c_DATA_FIRST)) begin
                    w_nextState = ARB_D_ADDR;
                end else if (w_instPend) begin
                    w_nextState = ARB_I_ADDR;
                end
            end
            ARB_D_ADDR: begin
                mem_req   = 1'b1;
                mem_wr    = |data_wen;
                mem_wstrb = data_wen;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
                if (mem_addr_ok) begin
                    w_nextState = ARB_D_DATA;
                end
            end
            ARB_D_DATA: begin
                if (mem_data_ok) begin
                    w_dataSet   = 1'b1;
                    w_nextState = ARB_IDLE;
                end
            end
            ARB_I_ADDR: begin
                mem_req  = 1'b1;
                mem_addr = inst_addr;
                if (mem_addr_ok) begin
                    w_nextState = ARB_I_DATA;
                end
            end
            ARB_I_DATA: begin
                if (mem_data_ok) begin
                    w_instSet   = 1'b1;
                    w_nextState = ARB_IDLE;
                end
            end
            default: begin
                w_nextState = ARB_IDLE;
            end
        endcase
    end

    // A completion landing on the same edge as a pipeline release must survive it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instDone <= 1'b0;
            r_dataDone <= 1'b0;
            r_instBuf  <= '0;
            r_dataBuf  <= '0;
        end else begin
            if (w_instSet) begin
                r_instDone <= 1'b1;
                r_instBuf  <= mem_rdata;
            end else if (!longest_stall) begin
                r_instDone <= 1'b0;
            end
            if (w_dataSet) begin
                r_dataDone <= 1'b1;
                r_dataBuf  <= mem_rdata;
            end else if (!longest_stall) begin
                r_dataDone <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
